// File: rtl/safety_island_soc_ctrl_resp.sv
// SocCtrl responder for the safety-island peripheral bus: boot address, fetch enable,
// core status and bootmode registers, plus the autoboot sequencer.
//
// state  | meaning
// SAMPLE | first cycle after reset release, latch bootmode strap
// COUNT  | Preloaded mode, counting down to automatic fetch enable
// DONE   | autoboot finished or cancelled, terminal until reset
module safety_island_soc_ctrl_resp #(
  parameter logic [31:0] BootAddrDefault = 32'h0000_0000,
  parameter int unsigned PreloadDelay    = 16,
  parameter int unsigned AddrWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           bootmode_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_en_o,
  output logic [31:0]          core_status_o,
  output logic                 eoc_o
);

  localparam int unsigned CntW = (PreloadDelay > 0) ? $clog2(PreloadDelay + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(PreloadDelay);

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    COUNT  = 2'd1,
    DONE   = 2'd2
  } boot_state_e;

  boot_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      bootmode_q;
  logic            latch_bootmode;
  logic            autoboot_set;

  logic [31:0] boot_addr_q;
  logic [31:0] core_status_q;
  logic        fetch_en_q;

  logic        sel_bootaddr, sel_fetchen, sel_corestatus, sel_bootmode;
  logic        addr_ok, req_err;
  logic        wr_bootaddr, wr_fetchen, wr_corestatus;
  logic [31:0] rd_val;

  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  // Only the 4 KiB window offset is decoded; byte lane and upper bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr_i[AddrWidth-1:12], addr_i[1:0]};

  function automatic logic [31:0] merge_bytes(logic [31:0] old_val, logic [31:0] new_val,
                                              logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign gnt_o = req_i;

  assign sel_bootaddr   = (addr_i[11:2] == 10'h000);
  assign sel_fetchen    = (addr_i[11:2] == 10'h001);
  assign sel_corestatus = (addr_i[11:2] == 10'h002);
  assign sel_bootmode   = (addr_i[11:2] == 10'h003);
  assign addr_ok        = sel_bootaddr | sel_fetchen | sel_corestatus | sel_bootmode;
  assign req_err        = ~addr_ok | (we_i & sel_bootmode);

  assign wr_bootaddr   = req_i & we_i & sel_bootaddr;
  assign wr_fetchen    = req_i & we_i & sel_fetchen;
  assign wr_corestatus = req_i & we_i & sel_corestatus;

  always_comb begin
    rd_val = '0;
    if (sel_bootaddr)   rd_val = boot_addr_q;
    if (sel_fetchen)    rd_val = {31'b0, fetch_en_q};
    if (sel_corestatus) rd_val = core_status_q;
    if (sel_bootmode)   rd_val = {30'b0, bootmode_q};
  end

  // Boot FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= SAMPLE;
      cnt_q      <= '0;
      bootmode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_bootmode) bootmode_q <= bootmode_i;
    end
  end

  // Boot FSM: next state; a debugger write to FETCHEN always ends the sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SAMPLE: begin
        if (bootmode_i == 2'b01) begin
          state_d = COUNT;
          cnt_d   = CntInit;
        end else begin
          state_d = DONE;
        end
      end
      COUNT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      DONE:    state_d = DONE;
      default: state_d = DONE;
    endcase
    if (wr_fetchen && (state_q != DONE)) state_d = DONE;
  end

  // Boot FSM: outputs
  always_comb begin
    latch_bootmode = (state_q == SAMPLE);
    autoboot_set   = (state_q == COUNT) && (cnt_q == '0) && !wr_fetchen;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      boot_addr_q   <= BootAddrDefault;
      core_status_q <= '0;
      fetch_en_q    <= 1'b0;
    end else begin
      if (wr_bootaddr)   boot_addr_q   <= merge_bytes(boot_addr_q, wdata_i, be_i);
      if (wr_corestatus) core_status_q <= merge_bytes(core_status_q, wdata_i, be_i);
      if (wr_fetchen) begin
        if (be_i[0]) fetch_en_q <= wdata_i[0];
      end else if (autoboot_set) begin
        fetch_en_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & req_err;
      rdata_q  <= (req_i && !we_i && !req_err) ? rd_val : 32'h0;
    end
  end

  assign rvalid_o      = rvalid_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign boot_addr_o   = boot_addr_q;
  assign fetch_en_o    = fetch_en_q;
  assign core_status_o = core_status_q;
  assign eoc_o         = core_status_q[31];

endmodule

// File: tb/tb_safety_island_soc_ctrl_resp.sv
// Directed bench for safety_island_soc_ctrl_resp: register map, error responses,
// autoboot timing for PreloadDelay 16 and 0, cancellation and mid-transaction reset.
module tb_safety_island_soc_ctrl_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bootmode;
  logic        req;
  logic        req0;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt, rvalid, err, fetch_en, eoc;
  logic [31:0] rdata, boot_addr, core_status;

  logic        gnt0, rvalid0, err0, fetch_en0, eoc0;
  logic [31:0] rdata0, boot_addr0, core_status0;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk = ~clk;

  safety_island_soc_ctrl_resp #(.PreloadDelay(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bootmode_i(bootmode),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .boot_addr_o(boot_addr), .fetch_en_o(fetch_en), .core_status_o(core_status), .eoc_o(eoc)
  );

  safety_island_soc_ctrl_resp #(.PreloadDelay(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bootmode_i(bootmode),
    .req_i(req0), .gnt_o(gnt0), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
    .boot_addr_o(boot_addr0), .fetch_en_o(fetch_en0), .core_status_o(core_status0), .eoc_o(eoc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Holds reset for two edges; the next edge after return is the first with rst_n=1.
  task automatic do_reset(input logic [1:0] bm);
    rst_n = 1'b0;
    req = 1'b0;
    bootmode = bm;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives one request through its grant edge; response is observable on return.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    tick();
    req = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic e, input logic [31:0] d);
    chk1({tag, "_rvalid"}, rvalid, 1'b1);
    chk1({tag, "_err"}, err, e);
    chk32({tag, "_rdata"}, rdata, d);
  endtask

  initial begin
    rst_n = 1'b0; bootmode = 2'b00; req = 1'b0; req0 = 1'b0;
    addr = '0; we = 1'b0; be = 4'h0; wdata = '0;

    // Reset values, Jtag strap
    do_reset(2'b00);
    rst_n = 1'b0;
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_boot_addr", boot_addr, 32'h0);
    chk1("rst_fetch_en", fetch_en, 1'b0);
    chk32("rst_core_status", core_status, 32'h0);
    chk1("rst_eoc", eoc, 1'b0);
    chk1("rst_gnt_idle", gnt, 1'b0);
    req = 1'b1; #1;
    chk1("rst_gnt_req", gnt, 1'b1);
    req = 1'b0;
    rst_n = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen = seen | fetch_en | fetch_en0;
    end
    chk1("jtag_no_autoboot", seen, 1'b0);

    req = 1'b1; we = 1'b1; addr = 32'h004; be = 4'hF; wdata = 32'h1; #1;
    chk1("gnt_follows_req", gnt, 1'b1);
    tick();
    req = 1'b0;
    chk_resp("wr_fetchen", 1'b0, 32'h0);
    chk1("jtag_fetch_en", fetch_en, 1'b1);
    tick();
    chk1("idle_rvalid", rvalid, 1'b0);

    // Partial write then back-to-back read
    req = 1'b1; we = 1'b1; addr = 32'h000; be = 4'b0011; wdata = 32'h1C00_0080;
    tick();
    chk_resp("wr_bootaddr", 1'b0, 32'h0);
    we = 1'b0; addr = 32'h000;
    tick();
    req = 1'b0;
    chk_resp("rd_bootaddr", 1'b0, 32'h0000_0080);
    chk32("boot_addr_o", boot_addr, 32'h0000_0080);

    access(1'b1, 32'h008, 4'hF, 32'h8000_002A);
    chk_resp("wr_corestatus", 1'b0, 32'h0);
    chk1("eoc_set", eoc, 1'b1);
    chk32("core_status_o", core_status, 32'h8000_002A);
    access(1'b0, 32'h1000_000B, 4'h0, 32'h0);
    chk_resp("rd_corestatus_alias", 1'b0, 32'h8000_002A);
    access(1'b0, 32'h004, 4'h0, 32'h0);
    chk_resp("rd_fetchen", 1'b0, 32'h1);
    access(1'b1, 32'h000, 4'h0, 32'hFFFF_FFFF);
    chk_resp("wr_be0", 1'b0, 32'h0);
    chk32("be0_boot_addr", boot_addr, 32'h0000_0080);

    // Error responses leave state untouched
    access(1'b0, 32'h010, 4'h0, 32'h0);
    chk_resp("rd_0x010", 1'b1, 32'h0);
    access(1'b0, 32'hFFC, 4'h0, 32'h0);
    chk_resp("rd_0xffc", 1'b1, 32'h0);
    access(1'b1, 32'h00C, 4'hF, 32'hFFFF_FFFF);
    chk_resp("wr_bootmode", 1'b1, 32'h0);
    access(1'b1, 32'h010, 4'hF, 32'h1234_5678);
    chk_resp("wr_0x010", 1'b1, 32'h0);
    chk32("err_boot_addr", boot_addr, 32'h0000_0080);
    chk32("err_core_status", core_status, 32'h8000_002A);
    chk1("err_fetch_en", fetch_en, 1'b1);
    access(1'b0, 32'h00C, 4'h0, 32'h0);
    chk_resp("rd_bootmode_jtag", 1'b0, 32'h0);

    // Preloaded autoboot timing: 18 cycles for delay 16, 2 cycles for delay 0
    do_reset(2'b01);
    seen = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1) chk1("pd0_fetch_en_c1", fetch_en0, 1'b0);
      if (k == 2) chk1("pd0_fetch_en_c2", fetch_en0, 1'b1);
      if (k <= 17) seen = seen | fetch_en;
    end
    chk1("pd16_early", seen, 1'b0);
    chk1("pd16_fetch_en_c18", fetch_en, 1'b1);
    bootmode = 2'b00;
    tick();
    access(1'b0, 32'h00C, 4'h0, 32'h0);
    chk_resp("rd_bootmode_latched", 1'b0, 32'h1);

    // Debugger write at cycle 5 cancels autoboot
    do_reset(2'b01);
    for (int k = 1; k <= 4; k++) tick();
    access(1'b1, 32'h004, 4'hF, 32'h0);
    chk_resp("cancel_c5", 1'b0, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      seen = seen | fetch_en;
    end
    chk1("cancel_c5_no_rise", seen, 1'b0);

    // Debugger write on the terminal-count cycle suppresses the autoboot set
    do_reset(2'b01);
    for (int k = 1; k <= 17; k++) tick();
    access(1'b1, 32'h004, 4'hF, 32'h0);
    chk1("cancel_tc_fetch_en", fetch_en, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | fetch_en;
    end
    chk1("cancel_tc_no_rise", seen, 1'b0);

    // Reset landing on a granted write drops the response and the write
    access(1'b1, 32'h004, 4'hF, 32'h1);
    access(1'b1, 32'h008, 4'hF, 32'h8000_0001);
    chk1("pre_rst_fetch_en", fetch_en, 1'b1);
    req = 1'b1; we = 1'b1; addr = 32'h000; be = 4'hF; wdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    tick();
    req = 1'b0;
    chk1("midrst_rvalid", rvalid, 1'b0);
    chk32("midrst_boot_addr", boot_addr, 32'h0);
    chk1("midrst_fetch_en", fetch_en, 1'b0);
    chk1("midrst_eoc", eoc, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("post_rst_rvalid", rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/safety_island_soc_ctrl_resp.md
Name: safety_island_soc_ctrl_resp

Overview:
- Responder (target) side of the safety-island peripheral bus for the SocCtrl window (4 KiB at periph offset 0x000).
- Decodes OBI-style single-beat requests into a small register file: boot address, fetch enable, core status/end-of-computation and bootmode readback.
- Contains the autoboot sequencer: in Preloaded bootmode it raises fetch enable after a programmable delay; in Jtag mode it waits for a debugger write.

Parameters:
- BootAddrDefault, 32'h0000_0000, reset value of BOOTADDR register.
- PreloadDelay, 16, cycles from bootmode sampling to automatic fetch enable in Preloaded mode (0 allowed).
- AddrWidth, 32, request address width; only bits [11:0] are decoded.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- bootmode_i  in  2  boot mode strap (2'b00 Jtag, 2'b01 Preloaded).
- req_i  in  1  request valid.
- gnt_o  out  1  request grant.
- addr_i  in  AddrWidth  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables (writes only).
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data (0 for writes and errors).
- err_o  out  1  response error, qualified by rvalid_o.
- boot_addr_o  out  32  BOOTADDR register to core.
- fetch_en_o  out  1  FETCHEN bit0 to core.
- core_status_o  out  32  CORESTATUS register.
- eoc_o  out  1  end of computation, CORESTATUS[31].

Behaviour:
- Clock/reset: one clock (clk_i); rst_ni is synchronous and active-low. All state is reset on a clk_i edge with rst_ni=0, including mid-transaction. A pending response is dropped (rvalid_o=0 the cycle after).
- Reset values: gnt_o follows req_i combinationally (asserted only while req_i=1). rvalid_o=0, err_o=0, rdata_o=0, boot_addr_o=BootAddrDefault, fetch_en_o=0, core_status_o=0, eoc_o=0. FSM is in SAMPLE.
- Handshake: gnt_o=req_i; there is no backpressure. A granted request gets exactly one response with rvalid_o=1 on the next cycle. Back-to-back requests each cycle are supported, giving continuous rvalid_o.
- Register map, decoded on addr_i[11:2], with addr_i[1:0] ignored:
  - 0x00 BOOTADDR: RW, full 32 bits.
  - 0x04 FETCHEN: RW, bit0 only; other bits read 0.
  - 0x08 CORESTATUS: RW, full 32 bits.
  - 0x0C BOOTMODE: RO, reads {30'b0, latched bootmode}.
  - Any other offset: err_o=1, rdata_o=0, no state change.
  - A write to BOOTMODE: err_o=1, no state change.
- Writes: applied at the grant edge, per byte according to be_i. be_i=0 is legal, responds OK and changes nothing.
- Reads: return the register value after all earlier granted writes. A write followed next cycle by a read returns the new value.
- Boot FSM:
  - SAMPLE (1 cycle after reset release): latch bootmode_i. If it is Preloaded, go to COUNT with counter=PreloadDelay. Otherwise go to DONE; 2'b10/2'b11 are treated as Jtag.
  - COUNT: when counter==0, set FETCHEN[0]=1 and go to DONE; else decrement. With PreloadDelay=0, fetch_en_o rises 2 cycles after reset release. In general it rises PreloadDelay+2 cycles after reset release.
  - DONE: terminal until reset.
  - Any granted write to FETCHEN while in SAMPLE or COUNT takes precedence. Its data is applied, autoboot is cancelled and the FSM goes to DONE. A same-cycle autoboot set is suppressed.
  - Counter width is $clog2(PreloadDelay+1), minimum 1.
- bootmode_i changes after SAMPLE are ignored; BOOTMODE reads the latched value.
- eoc_o is CORESTATUS[31] and is combinational from the register.

Test Plan:
- Reset, bootmode_i=2'b00: fetch_en_o stays 0 for 100 cycles. Write FETCHEN=1 -> fetch_en_o=1 the cycle after grant; rvalid_o=1, err_o=0 the cycle after grant.
- bootmode_i=2'b01, PreloadDelay=16: fetch_en_o rises exactly 18 cycles after reset release. With PreloadDelay=0 it rises at 2 cycles.
- Preloaded mode: write FETCHEN=0 at cycle 5 after reset release -> fetch_en_o never rises and the FSM is in DONE. Also cover the write landing on the counter==0 cycle -> fetch_en_o=0.
- Write BOOTADDR=0x1C00_0080 with be_i=4'b0011, then a back-to-back read -> rdata_o=0x0000_0080 (from default 0). Write CORESTATUS=0x8000_002A -> eoc_o=1.
- Read 0x010, read 0xFFC and write BOOTMODE -> err_o=1 and rdata_o=0 on each; registers unchanged. Read BOOTMODE with strap 2'b01 latched, then strap changed to 2'b00 -> reads 0x1.
- Assert rst_ni=0 the same cycle as a granted write of BOOTADDR -> no response the next cycle; BOOTADDR=BootAddrDefault and fetch_en_o=0.
